// File: rtl/bcd_disp_pkg.sv
// Shared constants for the seven-segment display path: active-low
// gfedcba glyphs for hex codes 0-F plus the all-dark patterns.
package bcd_disp_pkg;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] AN_OFF  = 4'b1111;

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational 4-bit code to active-low gfedcba segment decoder;
// codes A-F render as hex letters.
module hex_to_sseg
    import bcd_disp_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_0;
        case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            default: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/bcd_sseg_disp_mux.sv
// Four-digit time-multiplexed seven-segment driver with a once-per-frame
// input snapshot. Define LEAD_ZERO_BLANK_EN to suppress leading zeros.
module bcd_sseg_disp_mux
    import bcd_disp_pkg::*;
#(
    parameter int N = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] hex3,
    input  logic [3:0] hex2,
    input  logic [3:0] hex1,
    input  logic [3:0] hex0,
    input  logic [3:0] dp_in,
    input  logic       blank,
    output logic [3:0] an,
    output logic [7:0] sseg
);

    logic [N-1:0] q_reg;
    logic [N-1:0] q_next;
    logic [1:0]   sel;
    logic         frame_end;

    logic [3:0]   hex_in [4];
    logic [3:0]   hex_snap_reg [4];
    logic [3:0]   dp_snap_reg;
    logic [3:0]   dark;

    logic [6:0]   seg7;
    logic [3:0]   an_reg;
    logic [3:0]   an_next;
    logic [7:0]   sseg_reg;
    logic [7:0]   sseg_next;

    assign hex_in[0] = hex0;
    assign hex_in[1] = hex1;
    assign hex_in[2] = hex2;
    assign hex_in[3] = hex3;

    assign q_next    = q_reg + N'(1);
    assign sel       = q_reg[N-1:N-2];
    assign frame_end = &q_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    // Snapshot taken on the last cycle of a frame so the whole next frame
    // shows one coherent set of digits.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_snap
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    hex_snap_reg[gi] <= '0;
                    dp_snap_reg[gi]  <= 1'b0;
                end else if (frame_end) begin
                    hex_snap_reg[gi] <= hex_in[gi];
                    dp_snap_reg[gi]  <= dp_in[gi];
                end
            end
        end
    endgenerate

`ifdef LEAD_ZERO_BLANK_EN
    assign dark[3] = (hex_snap_reg[3] == 4'h0);
    assign dark[2] = dark[3] && (hex_snap_reg[2] == 4'h0);
    assign dark[1] = dark[2] && (hex_snap_reg[1] == 4'h0);
    assign dark[0] = 1'b0;
`else
    assign dark = 4'b0000;
`endif

    hex_to_sseg u_hex_to_sseg (
        .hex (hex_snap_reg[sel]),
        .seg (seg7)
    );

    always_comb begin
        an_next   = AN_OFF;
        sseg_next = SEG_OFF;
        if (!blank && !dark[sel]) begin
            an_next   = ~(4'b0001 << sel);
            sseg_next = {~dp_snap_reg[sel], seg7};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_reg   <= AN_OFF;
            sseg_reg <= SEG_OFF;
        end else begin
            an_reg   <= an_next;
            sseg_reg <= sseg_next;
        end
    end

    assign an   = an_reg;
    assign sseg = sseg_reg;

endmodule

// File: tb/tb_bcd_sseg_disp_mux.sv
// Directed bench for bcd_sseg_disp_mux at N=4 (4 clks per digit, 16 per frame);
// expectations follow LEAD_ZERO_BLANK_EN when it is defined.
module tb_bcd_sseg_disp_mux;

    localparam int N = 4;

`ifdef LEAD_ZERO_BLANK_EN
    localparam logic [3:0] LZ_DARK = 4'b1110;
`else
    localparam logic [3:0] LZ_DARK = 4'b0000;
`endif
    localparam int NEVER = 99;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] hex3 = 4'h0;
    logic [3:0] hex2 = 4'h0;
    logic [3:0] hex1 = 4'h0;
    logic [3:0] hex0 = 4'h0;
    logic [3:0] dp_in = 4'h0;
    logic       blank = 1'b0;
    logic [3:0] an;
    logic [7:0] sseg;

    int check_count = 0;
    int pass_count  = 0;

    bcd_sseg_disp_mux #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .hex3  (hex3),
        .hex2  (hex2),
        .hex1  (hex1),
        .hex0  (hex0),
        .dp_in (dp_in),
        .blank (blank),
        .an    (an),
        .sseg  (sseg)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        check_count++;
        if (got === exp) pass_count++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Runs one 16-cycle frame from a negedge that precedes the frame's first
    // output cycle. exp_seg packs {slot3,slot2,slot1,slot0}; dark marks slots
    // expected fully off. Blank is driven for cycles [bs, bs+bl). New inputs
    // are driven at cycle apply_at and are expected from the next frame.
    task automatic run_frame(input string tag, input logic [31:0] exp_seg,
                             input logic [3:0] dark, input int bs, input int bl,
                             input int apply_at, input logic [15:0] nhex,
                             input logic [3:0] ndp);
        logic       off;
        logic [7:0] exp_an;
        logic [7:0] exp_ss;
        int         slot;
        for (int j = 0; j < 16; j++) begin
            if (j == apply_at) begin
                {hex3, hex2, hex1, hex0} = nhex;
                dp_in = ndp;
            end
            blank = (j >= bs) && (j < bs + bl);
            off   = blank;
            @(posedge clk);
            @(negedge clk);
            slot = j / 4;
            off  = off || dark[slot];
            exp_an = off ? 8'h0F : {4'h0, ~(4'b0001 << slot)};
            exp_ss = off ? 8'hFF : exp_seg[slot*8 +: 8];
            check_val($sformatf("%s an c%0d", tag, j), {4'h0, an}, exp_an);
            check_val($sformatf("%s sseg c%0d", tag, j), sseg, exp_ss);
        end
        blank = 1'b0;
    endtask

    initial begin
        // Reset held from time zero.
        repeat (2) @(negedge clk);
        check_val("reset an", {4'h0, an}, 8'h0F);
        check_val("reset sseg", sseg, 8'hFF);
        reset = 1'b0;

        run_frame("zero", {4{8'hC0}}, LZ_DARK, NEVER, 0, 0, 16'h4321, 4'h0);
        run_frame("scan", {8'h99, 8'hB0, 8'hA4, 8'hF9}, 4'b0000, NEVER, 0, 9, 16'h4328, 4'h0);
        run_frame("tear", {8'h99, 8'hB0, 8'hA4, 8'h80}, 4'b0000, NEVER, 0, 2, 16'h4358, 4'b0010);
        run_frame("dp", {8'h99, 8'hB0, 8'h12, 8'h80}, 4'b0000, NEVER, 0, NEVER, 16'h0, 4'h0);
        run_frame("blank", {8'h99, 8'hB0, 8'h12, 8'h80}, 4'b0000, 5, 6, 0, 16'h0007, 4'h0);
        run_frame("lz7", {8'hC0, 8'hC0, 8'hC0, 8'hF8}, LZ_DARK, NEVER, 0, 0, 16'h0000, 4'h0);
        run_frame("lz0", {4{8'hC0}}, LZ_DARK, NEVER, 0, 0, 16'h4321, 4'h0);

        // Asynchronous reset mid-frame: outputs go dark before any clock edge.
        repeat (6) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_val("midrst an", {4'h0, an}, 8'h0F);
        check_val("midrst sseg", sseg, 8'hFF);
        @(negedge clk);
        reset = 1'b0;
        run_frame("postrst", {4{8'hC0}}, LZ_DARK, NEVER, 0, NEVER, 16'h0, 4'h0);
        run_frame("rescan", {8'h99, 8'hB0, 8'hA4, 8'hF9}, 4'b0000, NEVER, 0, NEVER, 16'h0, 4'h0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
